// File: rtl/lock_key_sequencer.sv
// Key-load and evaluation sequencer for an XOR key-locked combinational core.
// Optional macro LOCK_OUT_BLANK_EN blanks out_data whenever no verified key is committed.
module lock_key_sequencer #(
  parameter int KEY_W      = 8,
  parameter int IN_W       = 41,
  parameter int OUT_W      = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic             key_sv,
  input  logic             key_sd,
  output logic             key_ready,
  output logic             key_err,
  output logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_pseudo,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int SH_W = 2*KEY_W + 1;
  localparam int BC_W = $clog2(SH_W + 1);
  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(SH_W - 1);
  localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE_CYC);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, READY, EVAL, HOLD, ERROR} state_t;

  state_t           state;
  logic [SH_W-1:0]  shreg;
  logic [BC_W-1:0]  bitcnt;
  logic [SC_W-1:0]  settle;
  logic [OUT_W-1:0] res_p1;
  logic             start_load;

  function automatic logic parity_ok(input logic [SH_W-1:0] v);
    return ~(^v);
  endfunction

  assign start_load = key_load && (state inside {IDLE, LOAD, READY, ERROR});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      settle     <= '0;
      key_ready  <= 1'b0;
      key_err    <= 1'b0;
      key_in     <= '0;
      key_pseudo <= '0;
      in_ready   <= 1'b0;
      core_in    <= '0;
      out_valid  <= 1'b0;
      res_p1     <= '0;
    end else if (start_load) begin
      // Any (re)start drops the old key before a single new bit arrives
      state      <= LOAD;
      shreg      <= '0;
      bitcnt     <= '0;
      key_ready  <= 1'b0;
      key_err    <= 1'b0;
      key_in     <= '0;
      key_pseudo <= '0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (key_sv) begin
            shreg <= {shreg[SH_W-2:0], key_sd};
            if (bitcnt == LAST_BIT) begin
              state <= CHECK;
            end else begin
              bitcnt <= bitcnt + BC_W'(1);
            end
          end
        end
        CHECK: begin
          if (parity_ok(shreg)) begin
            key_in     <= shreg[SH_W-1 -: KEY_W];
            key_pseudo <= shreg[KEY_W -: KEY_W];
            key_ready  <= 1'b1;
            in_ready   <= 1'b1;
            state      <= READY;
          end else begin
            key_err <= 1'b1;
            state   <= ERROR;
          end
        end
        // Input launch: p0 is the core_in register, p1 the captured result
        READY: begin
          if (in_valid && in_ready) begin
            core_in  <= in_data;
            settle   <= SETTLE_INIT;
            in_ready <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (settle == '0) begin
`ifdef LOCK_OUT_BLANK_EN
            if (key_ready) begin
              res_p1    <= core_out;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              res_p1    <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
`else
            res_p1    <= core_out;
            out_valid <= 1'b1;
            state     <= HOLD;
`endif
          end else begin
            settle <= settle - SC_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= READY;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOCK_OUT_BLANK_EN
  assign out_data = key_ready ? res_p1 : '0;
`else
  assign out_data = out_valid ? res_p1 : '0;
`endif

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Directed-plus-random bench for lock_key_sequencer against a stream/parity reference model.
module tb_lock_key_sequencer;

  localparam int KEY_W      = 8;
  localparam int IN_W       = 41;
  localparam int OUT_W      = 32;
  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_load, key_sv, key_sd;
  logic             key_ready, key_err;
  logic [KEY_W-1:0] key_in, key_pseudo;
  logic             in_valid, in_ready;
  logic [IN_W-1:0]  in_data, core_in;
  logic [OUT_W-1:0] core_out, out_data;
  logic             out_valid, out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lock_key_sequencer #(
    .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_sv(key_sv), .key_sd(key_sd),
    .key_ready(key_ready), .key_err(key_err),
    .key_in(key_in), .key_pseudo(key_pseudo),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in(core_in), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Stand-in locked core: 0x1_2345_6789 maps to 0xDEADBEEF
  function automatic logic [OUT_W-1:0] core_f(input logic [IN_W-1:0] x);
    return x[31:0] ^ {x[40:32], 23'h0} ^ 32'hFD68D966;
  endfunction

  assign core_out = core_f(core_in);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: 17-bit stream MSB first, accepted iff the total count of ones is even
  task automatic send_key(input logic [7:0] ki, input logic [7:0] kp, input logic par,
                          input int gap, input bit rnd_gap);
    logic [16:0] stream;
    logic        pass;
    int          n;
    int          g;
    stream = {ki, kp, par};
    pass   = ~(^stream);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("load_entry_ready", key_ready, 0);
    chk("load_entry_err", key_err, 0);
    chk("load_entry_keyin", key_in, 0);
    for (int i = 16; i >= 0; i--) begin
      key_sv = 1'b1;
      key_sd = stream[i];
      tick();
      key_sv = 1'b0;
      g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      for (int j = 0; j < g; j++) begin
        key_sd = 1'($urandom);
        tick();
      end
    end
    n = 0;
    while (!key_ready && !key_err && n < 8) begin
      tick();
      n++;
    end
    chk("key_done_bound", (n < 8), 1);
    chk("key_ready", key_ready, pass);
    chk("key_err", key_err, !pass);
    chk("key_in", key_in, pass ? ki : 8'h00);
    chk("key_pseudo", key_pseudo, pass ? kp : 8'h00);
    chk("in_ready_after_key", in_ready, pass);
  endtask

  task automatic do_eval(input logic [IN_W-1:0] x, input int bp);
    logic [OUT_W-1:0] exp;
    int               lat;
    exp = core_f(x);
    in_data  = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("eval_core_in", core_in, x);
    chk("eval_in_ready_low", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("eval_latency", lat, SETTLE_CYC + 1);
    chk("eval_out_data", out_data, exp);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data", out_data, exp);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_core_in", core_in, x);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_core_in", core_in, x);
  endtask

  initial begin
    logic [7:0] ki, kp;
    logic       par;
    rst = 1'b1;
    key_load = 1'b0; key_sv = 1'b0; key_sd = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_key_ready", key_ready, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_key_in", key_in, 0);
    chk("rst_key_pseudo", key_pseudo, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 0);

    // 0xA2/0x5C carry seven ones, so parity bit 1 makes the stream even
    send_key(8'hA2, 8'h5C, 1'b1, 0, 1'b0);
    do_eval(41'h1_2345_6789, 5);
    chk("eval_deadbeef", core_f(41'h1_2345_6789), 32'hDEADBEEF);

    send_key(8'hA2, 8'h5C, 1'b0, 0, 1'b0);
    in_data  = 41'h0_FFFF_0000;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("error_in_ready", in_ready, 0);
    chk("error_out_valid", out_valid, 0);
    chk("error_core_in", core_in, 41'h1_2345_6789);

    // Abandon a partial stream after nine bits, then reload with gaps
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      key_sv = 1'b1;
      key_sd = 1'($urandom);
      tick();
    end
    key_sv = 1'b0;
    send_key(8'h3C, 8'h81, 1'b0, 3, 1'b0);

    for (int it = 0; it < 6; it++) begin
      ki  = 8'($urandom);
      kp  = 8'($urandom);
      par = (^{ki, kp}) ^ ($urandom_range(3, 0) == 0);
      send_key(ki, kp, par, 2, 1'b1);
      if (~(^{ki, kp, par})) begin
        for (int e = 0; e < 2; e++) begin
          do_eval({9'($urandom), 32'($urandom)}, int'($urandom_range(4, 0)));
        end
      end
    end

    // Asynchronous reset in the middle of an evaluation
    ki = 8'($urandom);
    kp = 8'($urandom);
    send_key(ki, kp, ^{ki, kp}, 0, 1'b0);
    in_data  = 41'h1_0F0F_F0F0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_key_ready", key_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_key_in", key_in, 0);
    chk("arst_key_pseudo", key_pseudo, 0);
    chk("arst_core_in", core_in, 0);
    chk("arst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_core_in", core_in, 0);
    chk("post_rst_key_ready", key_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
